// File: rtl/ascon_ti_pkg.sv
// Ascon TI S-box scheduler: shared types, sizes and reference S-box.
// Words are ordered x0..x4 with x0 in the top 64 bits of a 320-bit share.
package ascon_ti_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int NCOL   = 64;
  localparam int NWORD  = 5;
  localparam int NSHARE = 3;

  localparam int X0_OFF = 256;
  localparam int X1_OFF = 192;
  localparam int X2_OFF = 128;
  localparam int X3_OFF = 64;
  localparam int X4_OFF = 0;

  function automatic int word_off(input int w);
    case (w)
      0:       return X0_OFF;
      1:       return X1_OFF;
      2:       return X2_OFF;
      3:       return X3_OFF;
      default: return X4_OFF;
    endcase
  endfunction

  // Unmasked column S-box; bit w of x and of the result is word xw.
  function automatic logic [4:0] ascon_sbox(input logic [4:0] x);
    logic [4:0] a;
    logic [4:0] t;
    logic [4:0] b;
    logic [4:0] y;
    a    = x;
    a[0] = x[0] ^ x[4];
    a[4] = x[4] ^ x[3];
    a[2] = x[2] ^ x[1];
    for (int i = 0; i < 5; i++) begin
      t[i] = ~a[(i + 1) % 5] & a[(i + 2) % 5];
    end
    b    = a ^ t;
    y    = b;
    y[1] = b[1] ^ b[0];
    y[0] = b[0] ^ b[4];
    y[3] = b[3] ^ b[2];
    y[2] = ~b[2];
    return y;
  endfunction

endpackage

// File: rtl/ascon_ti_sbox_col.sv
// One 3-share threshold-implementation Ascon S-box column.
// Bit 5*s+w of x_i / y_o is word xw of share s.
module ascon_ti_sbox_col
  import ascon_ti_pkg::*;
(
  input  logic [NSHARE*NWORD-1:0] x_i,
  output logic [NSHARE*NWORD-1:0] y_o
);

  function automatic logic [4:0] lin_in(input logic [4:0] x);
    logic [4:0] y;
    y    = x;
    y[0] = x[0] ^ x[4];
    y[4] = x[4] ^ x[3];
    y[2] = x[2] ^ x[1];
    return y;
  endfunction

  // Output share k is built only from shares p=k+1 and q=k+2, so no
  // single share ever meets all three inputs of the chi AND terms.
  function automatic logic [4:0] chi_share(
    input logic [4:0] p,
    input logic [4:0] q
  );
    logic [4:0] y;
    int a;
    int b;
    for (int i = 0; i < 5; i++) begin
      a    = (i + 1) % 5;
      b    = (i + 2) % 5;
      y[i] = p[i] ^ p[b]
           ^ (p[a] & p[b])
           ^ (p[a] & q[b])
           ^ (q[a] & p[b]);
    end
    return y;
  endfunction

  function automatic logic [4:0] lin_out(
    input logic [4:0] x,
    input logic       neg
  );
    logic [4:0] y;
    y    = x;
    y[1] = x[1] ^ x[0];
    y[0] = x[0] ^ x[4];
    y[3] = x[3] ^ x[2];
    y[2] = x[2] ^ neg;
    return y;
  endfunction

  logic [NWORD-1:0] l0;
  logic [NWORD-1:0] l1;
  logic [NWORD-1:0] l2;

  assign l0 = lin_in(x_i[0*NWORD +: NWORD]);
  assign l1 = lin_in(x_i[1*NWORD +: NWORD]);
  assign l2 = lin_in(x_i[2*NWORD +: NWORD]);

  // Only share 0 carries the final complement of x2.
  assign y_o[0*NWORD +: NWORD] = lin_out(chi_share(l1, l2), 1'b1);
  assign y_o[1*NWORD +: NWORD] = lin_out(chi_share(l2, l0), 1'b0);
  assign y_o[2*NWORD +: NWORD] = lin_out(chi_share(l0, l1), 1'b0);

endmodule

// File: rtl/ascon_ti_sbox_sched.sv
// Masked Ascon substitution layer: issues PAR TI columns per cycle,
// registers S-box outputs, then writes them back into the output shares.
module ascon_ti_sbox_sched
  import ascon_ti_pkg::*;
#(
  parameter int PAR    = 8,
  parameter bit REMASK = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [319:0]        s0_in,
  input  logic [319:0]        s1_in,
  input  logic [319:0]        s2_in,
  input  logic [10*PAR-1:0]   rnd,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  output logic [319:0]        s0_out,
  output logic [319:0]        s1_out,
  output logic [319:0]        s2_out,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(NCOL);
  localparam int SW = NSHARE * NWORD;

  state_e               state_q;
  logic [CW-1:0]        col_q;
  logic [CW-1:0]        col_d;
  logic [CW-1:0]        pipe_col_q;
  logic                 pipe_valid_q;
  logic [PAR-1:0][SW-1:0] pipe_q;
  logic [PAR-1:0][SW-1:0] sbox_y;
  logic [NCOL-1:0]      in_q  [NSHARE][NWORD];
  logic [NCOL-1:0]      out_q [NSHARE][NWORD];
  logic [319:0]         s_in  [NSHARE];
  logic                 issue;
  logic                 last;

  assign s_in[0] = s0_in;
  assign s_in[1] = s1_in;
  assign s_in[2] = s2_in;

  assign issue = (state_q == RUN) && (!REMASK || rnd_valid);
  assign col_d = col_q + CW'(PAR);
  assign last  = (col_q == CW'(NCOL - PAR));

  assign ready     = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign rnd_ready = REMASK && (state_q == RUN);

  assign s0_out = {out_q[0][0], out_q[0][1], out_q[0][2],
                   out_q[0][3], out_q[0][4]};
  assign s1_out = {out_q[1][0], out_q[1][1], out_q[1][2],
                   out_q[1][3], out_q[1][4]};
  assign s2_out = {out_q[2][0], out_q[2][1], out_q[2][2],
                   out_q[2][3], out_q[2][4]};

  for (genvar p = 0; p < PAR; p++) begin : g_col
    logic [NWORD-1:0] ra;
    logic [NWORD-1:0] rb;
    logic [SW-1:0]    x;

    assign ra = REMASK ? rnd[NWORD*p +: NWORD]         : '0;
    assign rb = REMASK ? rnd[NWORD*(PAR+p) +: NWORD]   : '0;

    // Refresh keeps the sum of the three shares unchanged.
    for (genvar w = 0; w < NWORD; w++) begin : g_word
      assign x[0*NWORD+w] = in_q[0][w][col_q + CW'(p)] ^ ra[w];
      assign x[1*NWORD+w] = in_q[1][w][col_q + CW'(p)] ^ rb[w];
      assign x[2*NWORD+w] = in_q[2][w][col_q + CW'(p)]
                          ^ ra[w] ^ rb[w];
    end

    ascon_ti_sbox_col u_col (
      .x_i (x),
      .y_o (sbox_y[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      pipe_col_q   <= '0;
      pipe_valid_q <= 1'b0;
      pipe_q       <= '0;
      for (int s = 0; s < NSHARE; s++) begin
        for (int w = 0; w < NWORD; w++) begin
          in_q[s][w]  <= '0;
          out_q[s][w] <= '0;
        end
      end
    end else begin
      pipe_valid_q <= issue;
      if (issue) begin
        pipe_q     <= sbox_y;
        pipe_col_q <= col_q;
        col_q      <= col_d;
      end
      if (pipe_valid_q) begin
        for (int p = 0; p < PAR; p++) begin
          for (int s = 0; s < NSHARE; s++) begin
            for (int w = 0; w < NWORD; w++) begin
              out_q[s][w][pipe_col_q + CW'(p)] <=
                pipe_q[p][NWORD*s + w];
            end
          end
        end
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            for (int s = 0; s < NSHARE; s++) begin
              for (int w = 0; w < NWORD; w++) begin
                in_q[s][w] <= s_in[s][word_off(w) +: NCOL];
              end
            end
            col_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (issue && last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_ti_sbox_sched.sv
// Bench for ascon_ti_sbox_sched: four builds (PAR 8/8/1/64) driven from
// one stimulus set, checked against a table-lookup Ascon S-box model.
module tb_ascon_ti_sbox_sched;

  localparam int ND = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start [ND];
  logic [319:0] s0_in;
  logic [319:0] s1_in;
  logic [319:0] s2_in;
  logic [639:0] rnd;
  logic         rnd_valid;
  logic         ready_w [ND];
  logic         rndr_w  [ND];
  logic         busy_w  [ND];
  logic         done_w  [ND];
  logic [319:0] o0 [ND];
  logic [319:0] o1 [ND];
  logic [319:0] o2 [ND];

  int checks = 0;
  int errors = 0;

  logic [4:0] sbox_tab [32];

  always #5 clk = ~clk;

  ascon_ti_sbox_sched #(.PAR(8), .REMASK(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start[0]), .ready(ready_w[0]),
    .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in),
    .rnd(rnd[79:0]), .rnd_valid(rnd_valid), .rnd_ready(rndr_w[0]),
    .s0_out(o0[0]), .s1_out(o1[0]), .s2_out(o2[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  ascon_ti_sbox_sched #(.PAR(8), .REMASK(1'b0)) u_nr (
    .clk(clk), .rst(rst), .start(start[1]), .ready(ready_w[1]),
    .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in),
    .rnd(rnd[79:0]), .rnd_valid(rnd_valid), .rnd_ready(rndr_w[1]),
    .s0_out(o0[1]), .s1_out(o1[1]), .s2_out(o2[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  ascon_ti_sbox_sched #(.PAR(1), .REMASK(1'b1)) u_p1 (
    .clk(clk), .rst(rst), .start(start[2]), .ready(ready_w[2]),
    .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in),
    .rnd(rnd[9:0]), .rnd_valid(rnd_valid), .rnd_ready(rndr_w[2]),
    .s0_out(o0[2]), .s1_out(o1[2]), .s2_out(o2[2]),
    .busy(busy_w[2]), .done(done_w[2])
  );

  ascon_ti_sbox_sched #(.PAR(64), .REMASK(1'b1)) u_p64 (
    .clk(clk), .rst(rst), .start(start[3]), .ready(ready_w[3]),
    .s0_in(s0_in), .s1_in(s1_in), .s2_in(s2_in),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rndr_w[3]),
    .s0_out(o0[3]), .s1_out(o1[3]), .s2_out(o2[3]),
    .busy(busy_w[3]), .done(done_w[3])
  );

  function automatic int par_of(input int d);
    case (d)
      2:       return 1;
      3:       return 64;
      default: return 8;
    endcase
  endfunction

  function automatic bit remask_of(input int d);
    return d != 1;
  endfunction

  function automatic logic [319:0] r320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [639:0] r640();
    return {r320(), r320()};
  endfunction

  // Column-wise S-box on the unshared state via the published table.
  function automatic logic [319:0] model(input logic [319:0] x);
    logic [319:0] y;
    logic [4:0]   idx;
    logic [4:0]   v;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      idx = {x[256+j], x[192+j], x[128+j], x[64+j], x[j]};
      v   = sbox_tab[idx];
      {y[256+j], y[192+j], y[128+j], y[64+j], y[j]} = v;
    end
    return y;
  endfunction

  task automatic chk(input string nm, input logic [319:0] got,
                     input logic [319:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic run_op(input int d, input logic [319:0] x,
                        input bit masked, input logic [319:0] want,
                        input int gap, input bit hold, input string nm);
    logic [319:0] a, b, c, q0, q1, q2;
    int n, iss, exp_k, got_k, w;
    bit rv;
    b = masked ? r320() : '0;
    c = masked ? r320() : '0;
    a = x ^ b ^ c;
    s0_in = a; s1_in = b; s2_in = c;
    start[d] = 1'b1;
    w = 0;
    while (!ready_w[d] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, ".rdy"}, ready_w[d], 1);
    @(posedge clk); #1;
    if (!hold) start[d] = 1'b0;
    s0_in = r320(); s1_in = r320(); s2_in = r320();
    chk({nm, ".busy"}, {busy_w[d], ready_w[d], rndr_w[d]},
        {1'b1, 1'b0, remask_of(d)});
    n = 64 / par_of(d);
    iss = 0; exp_k = -1; got_k = -1;
    for (int k = 1; k <= 200; k++) begin
      rv = ($urandom_range(99) >= gap);
      rnd_valid = rv;
      rnd = r640();
      if ((rv || !remask_of(d)) && iss < n) begin
        iss++;
        if (iss == n) exp_k = k + 1;
      end
      @(posedge clk); #1;
      if (done_w[d]) begin
        got_k = k;
        break;
      end
    end
    chk({nm, ".lat"}, got_k, exp_k);
    chk({nm, ".res"}, o0[d] ^ o1[d] ^ o2[d], want);
    chk({nm, ".dbusy"}, busy_w[d], 1);
    if (remask_of(d)) begin
      checks++;
      if (o0[d] === want) begin
        errors++;
        $display("FAIL %s.mask got=%0h want=not %0h", nm, o0[d], want);
      end
    end
    q0 = o0[d]; q1 = o1[d]; q2 = o2[d];
    rnd_valid = 1'b1;
    rnd = r640();
    @(posedge clk); #1;
    chk({nm, ".pulse"}, done_w[d], 0);
    chk({nm, ".stab"}, {o0[d] ^ q0, o1[d] ^ q1, o2[d] ^ q2}, '0);
    if (!hold) begin
      @(posedge clk); #1;
      chk({nm, ".idle"}, {ready_w[d], busy_w[d], done_w[d]}, 3'b100);
      chk({nm, ".stab2"}, {o0[d] ^ q0, o1[d] ^ q1, o2[d] ^ q2}, '0);
    end
  endtask

  typedef struct {
    logic [319:0] x;
    bit           masked;
    int           d;
    logic [319:0] want;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [63:0]  f;
    logic [63:0]  z;
    logic [63:0]  al;
    logic [319:0] x;
    sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    f  = '1;
    z  = '0;
    al = 64'hAAAA_AAAA_AAAA_AAAA;
    vt[0] = '{{z, z, z, z, z}, 1'b0, 1, {z, z, f, z, z}};
    vt[1] = '{{f, f, f, f, f}, 1'b1, 0, {f, z, f, f, f}};
    vt[2] = '{{f, z, z, z, z}, 1'b1, 0, {f, f, f, f, z}};
    vt[3] = '{{z, z, z, z, f}, 1'b1, 1, {z, f, z, f, f}};
    vt[4] = '{{al, z, z, z, z}, 1'b1, 0, {al, al, f, al, z}};
    vt[5] = '{{z, z, z, z, z}, 1'b0, 0, {z, z, f, z, z}};

    for (int d = 0; d < ND; d++) start[d] = 1'b0;
    s0_in = '0; s1_in = '0; s2_in = '0;
    rnd = '0; rnd_valid = 1'b1;
    rst = 1'b1;
    #12;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst%0d.ctl", d),
          {ready_w[d], busy_w[d], done_w[d], rndr_w[d]}, 4'b1000);
      chk($sformatf("rst%0d.out", d), o0[d] | o1[d] | o2[d], '0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].d, vt[i].x, vt[i].masked, vt[i].want, 0, 1'b0,
             $sformatf("vec%0d", i));
    end

    x = r320();
    run_op(0, x, 1'b1, model(x), 30, 1'b1, "b2b_a");
    x = r320();
    run_op(0, x, 1'b1, model(x), 0, 1'b0, "b2b_b");

    // Abort in the middle of RUN once columns 0..23 have issued.
    s0_in = r320(); s1_in = r320(); s2_in = r320();
    rnd_valid = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort.out", o0[0] | o1[0] | o2[0], '0);
    chk("abort.ctl", {ready_w[0], busy_w[0], done_w[0], rndr_w[0]},
        4'b1000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort.idle", {ready_w[0], busy_w[0]}, 2'b10);
    x = r320();
    run_op(0, x, 1'b1, model(x), 30, 1'b0, "abort.re");

    for (int i = 0; i < 1000; i++) begin
      x = r320();
      run_op(0, x, 1'b1, model(x), 30, 1'b0, $sformatf("rnd%0d", i));
    end
    for (int d = 1; d < ND; d++) begin
      for (int i = 0; i < 8; i++) begin
        x = r320();
        run_op(d, x, 1'b1, model(x), (i < 2) ? 0 : 30, 1'b0,
               $sformatf("d%0d_%0d", d, i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ascon_ti_sbox_sched.md
Name: ascon_ti_sbox_sched

Overview:
Sequences the Ascon 320-bit substitution layer through PAR copies of the 3-share threshold-implementation (TI) S-box column. It accepts three shares of the permutation state and issues PAR columns per cycle. Each S-box output is registered before recombination, as TI glitch-robustness requires. Fresh randomness optionally remasks each column, and the block returns three output shares with a done pulse. It sits between the round-constant/linear-layer controller and the state register in the masked Ascon core.

Parameters:
PAR, 8, S-box columns processed per cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REMASK, 1, 1 = refresh input shares with fresh randomness before the S-box; 0 = rnd ports ignored, no stalls.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request to process the state present on s0_in/s1_in/s2_in
ready  out  1  high in IDLE only; start accepted when start && ready
s0_in  in  320  share 0, word layout {x0,x1,x2,x3,x4}, x0 in [319:256]
s1_in  in  320  share 1, same layout
s2_in  in  320  share 2, same layout
rnd  in  10*PAR  fresh random bits: PAR x 5 bits r_a, then PAR x 5 bits r_b
rnd_valid  in  1  rnd holds fresh bits
rnd_ready  out  1  rnd consumed at a clock edge where rnd_valid && rnd_ready
s0_out  out  320  output share 0, same layout
s1_out  out  320  output share 1, same layout
s2_out  out  320  output share 2, same layout
busy  out  1  high in RUN, DRAIN and DONE
done  out  1  one-cycle pulse; s*_out valid and stable until the next accepted start

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, column counter 0, pipe_valid 0, s*_out all 0, ready 1, busy 0, done 0, rnd_ready 0. Reset mid-operation aborts the operation and discards partial results.
- Column j means bit j of each of x0..x4 within one share. N = 64/PAR.
- IDLE: when start && ready, latch s*_in into internal input buffers, set col = 0, go to RUN. start is ignored outside IDLE.
- RUN: rnd_ready = REMASK.
  - An issue cycle is any RUN cycle with (!REMASK || rnd_valid).
  - On an issue cycle, columns col..col+PAR-1 feed the S-box instances.
  - With REMASK, per column and bit: share0 ^= r_a, share1 ^= r_b, share2 ^= r_a^r_b, applied combinationally before the S-box.
  - On an issue cycle the PAR outputs are captured into the pipeline register with pipe_valid=1, and col += PAR.
  - On a stall cycle, col holds and pipe_valid = 0.
  - After the issue with col = 64-PAR, go to DRAIN. The counter wraps to 0 and is unused afterwards.
- Write-back: each cycle with pipe_valid=1, write the pipeline register into s*_out at pipe_col (the col value of that issue). No other s*_out bits change.
- DRAIN: final write-back occurs in this cycle; go to DONE.
- DONE: done = 1 for one cycle; go to IDLE.
- Latency with rnd_valid held high: start accepted at edge T, done high during cycle T+N+2. For PAR=8 this is 10 cycles.
- Each stall cycle adds exactly one cycle of latency.
- Correctness invariant: s0_out^s1_out^s2_out equals the Ascon S-box applied column-wise to s0_in^s1_in^s2_in, for any rnd and any stall pattern.
- No share is ever recombined inside the block; unshared values never appear on any net.
- rnd_valid while not in RUN: no effect, nothing consumed.

Decomposition:
- Package ascon_ti_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - NCOL=64, NWORD=5, NSHARE=3
  - word-offset constants for x0..x4
  - the Ascon S-box reference function, for the bench
- Sub-module ascon_ti_sbox_col: one 3-share TI column (15 bits in, 15 bits out, combinational), instantiated PAR times via generate.
- The scheduler owns the FSM, counter, input buffers, remask XORs, pipeline register and output write-back.

Test Plan:
- All-zero shares, REMASK=0, PAR=8, start -> done at T+10; recombined x2 = 0xFFFF_FFFF_FFFF_FFFF; x0, x1, x3, x4 = 0.
- State recombining to all-ones, with s1 and s2 random, REMASK=1, rnd random and rnd_valid=1 -> recombined x1 = 0; x0, x2, x3, x4 = all-ones; s0_out alone not equal to the unmasked result.
- 1000 random states and rnd with random rnd_valid gaps (30%) -> recombination matches the package S-box for every column; latency = 10 + number of stall cycles.
- Assert rst during RUN at col=24 -> all outputs zero immediately (async), ready=1 next cycle; a subsequent start completes correctly.
- start held high in RUN/DONE plus a back-to-back start in the cycle after done -> exactly one operation per accepted start; s*_out stable from done until the next acceptance.
- PAR=1 and PAR=64 builds -> done at T+66 and T+3 respectively; results correct.
